// File: rtl/wokwi_microtile_accum.sv
// -----------------------------------------------------------------------------
// wokwi_microtile_accum
//
// Purpose:
//   8-bit opcode-driven accumulator microtile. Every rising clock edge the
//   accumulator is updated by a 3-bit opcode acting on its own prior value
//   and a 5-bit unsigned operand. The accumulator drives the outputs directly.
//
// Ports:
//   clk     in   1  system clock, all state changes on the rising edge
//   rst     in   1  synchronous active-high reset (loads RESET_VALUE)
//   ui_in   in   8  [2:0] opcode, [7:3] operand K (unsigned 0..31)
//   uo_out  out  8  accumulator value, straight from the register
//
// Opcodes:
//   000 HOLD  001 LOAD  010 ADD  011 SUB  100 SHL  101 SHR  110 ROL  111 XOR
//
// Build option:
//   SATURATE_EN  when defined, ADD clamps at 8'hFF and SUB clamps at 8'h00
//                instead of wrapping. Port list is the same either way.
// -----------------------------------------------------------------------------
module wokwi_microtile_accum #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_XOR  = 3'b111
  } op_e;

  op_e        op;
  logic [7:0] k;
  logic [7:0] acc;
  logic [7:0] acc_next;
  logic [7:0] add_res;
  logic [7:0] sub_res;

  assign op = op_e'(ui_in[2:0]);
  assign k  = {3'b000, ui_in[7:3]};

`ifdef SATURATE_EN
  // Ninth bit carries the overflow (ADD) or borrow (SUB) used to clamp.
  logic [8:0] add_full;
  logic [8:0] sub_full;

  assign add_full = {1'b0, acc} + {1'b0, k};
  assign sub_full = {1'b0, acc} - {1'b0, k};
  assign add_res  = add_full[8] ? 8'hFF : add_full[7:0];
  assign sub_res  = sub_full[8] ? 8'h00 : sub_full[7:0];
`else
  // Plain 8-bit arithmetic; the carry/borrow is intentionally dropped.
  assign add_res = acc + k;
  assign sub_res = acc - k;
`endif

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // acc_next unassigned, which would infer a latch.
    acc_next = acc;
    unique case (op)
      OP_HOLD: acc_next = acc;
      OP_LOAD: acc_next = k;
      OP_ADD:  acc_next = add_res;
      OP_SUB:  acc_next = sub_res;
      OP_SHL:  acc_next = {acc[6:0], 1'b0};
      OP_SHR:  acc_next = {1'b0, acc[7:1]};
      OP_ROL:  acc_next = {acc[6:0], acc[7]};
      OP_XOR:  acc_next = acc ^ k;
      default: acc_next = acc;
    endcase
  end

  // Reset wins over any opcode presented in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples the pre-edge
    // values, independent of statement ordering between processes.
    if (rst) begin
      acc <= RESET_VALUE;
    end else begin
      acc <= acc_next;
    end
  end

  assign uo_out = acc;

endmodule

// File: tb/tb_wokwi_microtile_accum.sv
// -----------------------------------------------------------------------------
// tb_wokwi_microtile_accum
//
// Self-checking bench for wokwi_microtile_accum. An arithmetic model of the
// accumulator follows the stimulus and is compared against uo_out on every
// falling edge once a reset has been seen. Directed steps additionally pin
// hand-computed literal values. Honours SATURATE_EN the same way as the RTL.
// -----------------------------------------------------------------------------
module tb_wokwi_microtile_accum;

  logic       clk;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int n_checks = 0;
  int n_fail   = 0;

  int model_acc   = 0;
  bit model_valid = 1'b0;

  wokwi_microtile_accum #(.RESET_VALUE(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Accumulator semantics expressed as integer arithmetic on 0..255.
  function automatic int model_next(input int a, input int op, input int k);
    int r;
    case (op)
      0: r = a;
      1: r = k;
`ifdef SATURATE_EN
      2: r = (a + k > 255) ? 255 : a + k;
      3: r = (k > a) ? 0 : a - k;
`else
      2: r = (a + k) % 256;
      3: r = (a - k + 256) % 256;
`endif
      4: r = (a * 2) % 256;
      5: r = a / 2;
      6: r = (a * 2) % 256 + a / 128;
      default: r = a ^ k;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      model_acc   = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      model_acc = model_next(model_acc, int'(ui_in[2:0]), int'(ui_in[7:3]));
    end
  end

  always @(negedge clk) begin
    if (model_valid) check("model", uo_out, model_acc[7:0]);
  end

  // Present rst/ui_in, let one rising edge pass, then compare 1ns later.
  task automatic step(input string name, input logic r, input logic [7:0] ui,
                      input logic [7:0] exp);
    rst   = r;
    ui_in = ui;
    @(posedge clk);
    #1;
    check(name, uo_out, exp);
  endtask

  // Same as step but without a literal expectation (model check only).
  task automatic run(input logic r, input logic [7:0] ui);
    rst   = r;
    ui_in = ui;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_add16;
  logic [7:0] exp_sub1;

  initial begin
`ifdef SATURATE_EN
    exp_add16 = 8'hFF;
    exp_sub1  = 8'h00;
`else
    exp_add16 = 8'h08;
    exp_sub1  = 8'hFF;
`endif
    rst   = 1'b0;
    ui_in = 8'h00;
    @(posedge clk);
    #1;

    // Reset with all-ones input, then HOLD.
    step("rst_1",  1'b1, 8'hFF, 8'h00);
    step("rst_2",  1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 3; i++) step("hold_after_rst", 1'b0, 8'h00, 8'h00);

    // Load / add.
    step("load_31",  1'b0, 8'hF9, 8'h1F);
    step("add_31",   1'b0, 8'hFA, 8'h3E);
    step("add_1",    1'b0, 8'h0A, 8'h3F);

    // Wrap or saturate on ADD.
    step("load_31b", 1'b0, 8'hF9, 8'h1F);
    step("shl_a",    1'b0, 8'h04, 8'h3E);
    step("shl_b",    1'b0, 8'h04, 8'h7C);
    step("shl_c",    1'b0, 8'h04, 8'hF8);
    step("add_16",   1'b0, 8'h82, exp_add16);

    // Wrap or saturate on SUB.
    step("load_0",   1'b0, 8'h01, 8'h00);
    step("sub_1",    1'b0, 8'h0B, exp_sub1);

    // Shifts and rotate.
    step("load_13",  1'b0, 8'h99, 8'h13);
    step("shl_13",   1'b0, 8'h04, 8'h26);
    step("shr_26",   1'b0, 8'h05, 8'h13);
    step("load_10",  1'b0, 8'h81, 8'h10);
    step("shl_10",   1'b0, 8'h04, 8'h20);
    step("shl_20",   1'b0, 8'h04, 8'h40);
    step("shl_40",   1'b0, 8'h04, 8'h80);
    step("rol_80",   1'b0, 8'h06, 8'h01);

    // ROL x8 returns the original value.
    for (int i = 0; i < 7; i++) run(1'b0, 8'h06);
    step("rol_x8",   1'b0, 8'h06, 8'h01);

    // SHR x8 from F8 and SHL x8 from 1F both reach zero.
    step("load_31c", 1'b0, 8'hF9, 8'h1F);
    for (int i = 0; i < 3; i++) run(1'b0, 8'h04);
    for (int i = 0; i < 7; i++) run(1'b0, 8'h05);
    step("shr_x8",   1'b0, 8'h05, 8'h00);
    step("load_31d", 1'b0, 8'hF9, 8'h1F);
    for (int i = 0; i < 7; i++) run(1'b0, 8'h04);
    step("shl_x8",   1'b0, 8'h04, 8'h00);

    // Zero operands leave ACC unchanged.
    step("load_15",  1'b0, 8'hA9, 8'h15);
    step("add_0",    1'b0, 8'h02, 8'h15);
    step("sub_0",    1'b0, 8'h03, 8'h15);
    step("xor_0",    1'b0, 8'h07, 8'h15);

    // XOR then reset during an ADD cycle.
    step("xor_1f",   1'b0, 8'hFF, 8'h0A);
    step("rst_mid",  1'b1, 8'h2A, 8'h00);
    step("add_5",    1'b0, 8'h2A, 8'h05);

    // Opcode changing every cycle.
    step("mix_load", 1'b0, 8'h39, 8'h07);
    step("mix_rol",  1'b0, 8'h06, 8'h0E);
    step("mix_sub",  1'b0, 8'h13, 8'h0C);
    step("mix_xor",  1'b0, 8'hFF, 8'h13);
    step("mix_shr",  1'b0, 8'h05, 8'h09);

    // Literal pins on the model itself.
    n_checks++;
    if (model_next(200, 2, 31) != 231 || model_next(129, 6, 0) != 3 ||
        model_next(5, 7, 31) != 26) begin
      n_fail++;
      $display("FAIL model_pin: arithmetic model disagrees with hand values");
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wokwi_microtile_accum.md
Name: wokwi_microtile_accum

Overview:
- 8-bit opcode-driven accumulator microtile in the TinyTapeout microtiles collection.
- Each clock cycle, ui_in supplies a 3-bit opcode and a 5-bit operand that update one 8-bit accumulator.
- uo_out presents the accumulator directly.
- Stand-alone leaf block; the wrapper ties ui_in to chip inputs and uo_out to chip outputs.

Parameters:
- RESET_VALUE, 8'h00, accumulator value loaded by reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ui_in  input  8  [2:0] opcode, [7:3] operand (unsigned 5-bit, 0..31).
- uo_out  output  8  accumulator value (registered).
- Note: power pins vccd1/vssd1 exist only in the gate-level netlist; RTL has no power ports.

Behaviour:
- Register
  - One 8-bit accumulator ACC.
  - uo_out = ACC at all times; no combinational path from ui_in to uo_out.
- Reset
  - rst=1 at a rising clk edge sets ACC to RESET_VALUE.
  - Reset has priority over any opcode.
  - uo_out shows RESET_VALUE from the edge after rst sampled high.
  - Before the first reset ACC is undefined; the bench must not check it.
- Opcode decode
  - Sampled at every rising edge with rst=0. Effect is visible on uo_out after that edge (1-cycle latency).
  - OP = ui_in[2:0]; K = ui_in[7:3] zero-extended to 8 bits.
- Opcode map:
  - 000 HOLD: ACC unchanged.
  - 001 LOAD: ACC <= {3'b000, K}.
  - 010 ADD: ACC <= (ACC + K) mod 256.
  - 011 SUB: ACC <= (ACC - K) mod 256.
  - 100 SHL: ACC <= {ACC[6:0], 1'b0}.
  - 101 SHR: ACC <= {1'b0, ACC[7:1]}, logical.
  - 110 ROL: ACC <= {ACC[6:0], ACC[7]}.
  - 111 XOR: ACC <= ACC ^ K; upper 3 bits are unaffected.
- Arithmetic
  - Unsigned 8-bit.
  - Without the optional feature, ADD and SUB wrap silently; no carry or borrow output.
- Boundary conditions
  - ADD 0, SUB 0 and XOR 0 leave ACC unchanged.
  - SHL/SHR applied 8 times yield 0.
  - ROL applied 8 times returns the original value.
  - The opcode may change every cycle; each cycle's opcode acts on the prior ACC.
  - Reset asserted mid-sequence discards the pending operation; decoding resumes on the first edge with rst=0.

Optional Feature:
- Macro SATURATE_EN.
- When defined:
  - ADD clamps to 8'hFF when ACC+K > 255.
  - SUB clamps to 8'h00 when K > ACC.
  - All other opcodes unchanged.
- When undefined: wrap-around arithmetic as specified above.
- Port list is identical either way.

Test Plan:
- Reset: rst=1 for 2 cycles with ui_in=8'hFF -> uo_out=8'h00. Release rst with ui_in=0 (HOLD) for 3 cycles -> uo_out stays 8'h00.
- Load/add: LOAD K=31 (ui_in=8'hF9) -> 8'h1F. ADD K=31 (8'hFA) -> 8'h3E. ADD K=1 (8'h0A) -> 8'h3F.
- Wrap (SATURATE_EN off):
  - LOAD 31, then SHL x3 -> 8'hF8; ADD 16 -> 8'h08.
  - LOAD 0, SUB 1 -> 8'hFF.
- Saturate (SATURATE_EN on): same sequences -> 8'hFF and 8'h00 respectively.
- Shifts/rotate:
  - LOAD 8'h13, SHL -> 8'h26, SHR -> 8'h13.
  - LOAD 8'h10, SHL x3 -> 8'h80; ROL -> 8'h01.
- XOR + mid-sequence reset: LOAD 8'h15, XOR K=8'h1F -> 8'h0A. Assert rst during an ADD cycle -> uo_out=8'h00 next cycle, no add applied.
